tr_cnt_lvl: RTL
===============

# tr_cnt_lvl

Parametrised transaction grouper on `dti` streams. It passes a stream whose items carry `LVL_IN` end-of-transaction (eot) bits and counts completed top-level transactions. After `cfg` such transactions it closes a new outer level, so the output carries `LVL_IN+1` eot bits. It is the generalised successor of the single-level transaction counter: it adds arbitrary input eot depth, safe handling of `cfg == 0`, an optional registered output stage and a group-index side output. It sits between a data producer and any consumer that expects one extra nesting level.

## Interface
Parameters:
- `W_DATA`, 8: payload width, ≥1.
- `LVL_IN`, 1: input eot levels, ≥1.
- `W_CFG`, 16: width of the group-size configuration and of the counter.
- `OUT_REG`, 0: 0 = combinational pass-through; 1 = one full-throughput register stage on `dout`.

Ports:
- `clk  in  1`: clock.
- `rst  in  1`: reset, synchronous, active-high.
- `din  dti.consumer  W_DATA+LVL_IN`: input stream; data layout `{eot[LVL_IN-1:0], data[W_DATA-1:0]}`.
- `cfg  dti.consumer  W_CFG`: number of top-level transactions per output group.
- `dout  dti.producer  W_DATA+LVL_IN+1`: output stream; data layout `{eot[LVL_IN:0], data}`.
- `grp_idx  out  W_CFG`: index of the current transaction within its group, equal to `cnt_reg`.

## Operation
- **Transaction end:** a din item with `eot[LVL_IN-1] == 1`.
- **Effective group size:** `cfg_eff = (cfg.data == 0) ? 1 : cfg.data`. A value of 0 is never allowed to wrap the counter.
- **Counter:** `cnt_reg`, `W_CFG` bits. `last = (cnt_reg == cfg_eff-1)`, compared in `W_CFG` bits; no overflow is possible because `cnt_reg ≤ cfg_eff-1`.
- **Accept:** `acc = din.valid && din.ready`. `din.ready` already requires `cfg.valid`.
- **Output item mapping:**
  - `data` is passed through unchanged.
  - `eot[LVL_IN-1:0]` equals `din.eot`.
  - `eot[LVL_IN]` equals `last`. It is high for every item of the final transaction of the group, matching pygears outer-level semantics.
- **Group done:** `done = acc && din.eot[LVL_IN-1] && last`.
  - `cfg.ready = done`. cfg is consumed exactly on the accept of the final item of the group.
  - `cnt_reg` is cleared to 0 on `done`.
- **Counter increment:** when `acc && din.eot[LVL_IN-1] && !last`, `cnt_reg` increments by 1.
- **cfg stability:** cfg must hold its value while valid (dti rule). The block does not latch cfg.
- **OUT_REG = 0:**
  - `dout.valid = din.valid && cfg.valid`.
  - `din.ready = dout.ready && cfg.valid`.
  - `dout.data` is combinational from `din.data` and `cnt_reg`.
- **OUT_REG = 1:**
  - Output register `{ovalid, odata}`. `dout.valid = ovalid`, `dout.data = odata`.
  - `din.ready = cfg.valid && (!ovalid || dout.ready)`.
  - On `acc`, load `odata` and set `ovalid = 1`.
  - Otherwise, `dout.ready` clears `ovalid`.
- **grp_idx** always reflects `cnt_reg`, i.e. the value applying to the next accepted item.

## Timing
- **Reset values:**
  - `cnt_reg = 0`, `grp_idx = 0`, `cfg.ready = 0`.
  - OUT_REG = 1: `ovalid = 0`, so `dout.valid = 0`.
  - OUT_REG = 0: `dout.valid` follows `din.valid && cfg.valid` combinationally from the first cycle.
- **Latency:** 0 cycles for OUT_REG = 0; exactly 1 cycle for OUT_REG = 1. Both give 1 item/cycle sustained throughput when `dout.ready` is held high.
- **cfg.ready** is a single-cycle pulse in the accept cycle of the group's last item. The next cfg is sampled from the following cycle on.
- **Stalls:**
  - `cfg.valid = 0` → `din.ready = 0`.
  - OUT_REG = 0 only: `dout.valid = 0`.
  - OUT_REG = 1: an already-loaded item still drains.
- **Register stage:** with `dout.ready` low and `ovalid` high, `odata` holds and `din.ready = 0`. Simultaneous drain and load in the same cycle is allowed.
- **Reset mid-group:** the counter is cleared and the stage emptied. The partial group is abandoned, and the next accepted transaction is index 0. cfg is not acked.
- **Maximum group size:** `cfg = 2^W_CFG-1`; `last` is asserted at `cnt_reg = 2^W_CFG-2`.

## Test plan
- **Basic grouping (LVL_IN=1, OUT_REG=0):**
  - Stimulus: cfg=3; din items `(eot, data)` = (0,1),(1,2),(1,3),(0,4),(1,5).
  - Required: dout eot = 00, 01, 01, 10, 11 and data 1..5 in order.
  - Required: `cfg.ready` pulses once, on item 5; `grp_idx` sequence 0,0,1,2,2 then 0.
- **cfg = 0:**
  - Stimulus: three single-item transactions.
  - Required: each output has `eot[1] = 1`; cfg is acked on every item; `cnt_reg` stays 0.
- **Multi-level (LVL_IN=2, cfg=2):**
  - Stimulus: din eot sequence 00, 01, 11, 01, 11.
  - Required: output eot 000, 001, 011, 101, 111; one cfg ack, on the 5th item.
- **Backpressure (OUT_REG=1):**
  - Stimulus: stream 6 items with cfg=2; `dout.ready` toggles 1,0,0,1,…
  - Required: no loss or duplication; output matches the OUT_REG=0 golden model delayed by 1 cycle; `din.ready` is low whenever `ovalid && !dout.ready`.
- **cfg stall:**
  - Stimulus: hold `cfg.valid = 0` for 4 cycles with `din.valid = 1`.
  - Required: no din accepts; after cfg arrives, grouping starts at index 0.
- **Reset mid-group:**
  - Stimulus: cfg=4, 2 transactions accepted, then assert `rst` for 1 cycle.
  - Required: `grp_idx = 0`, `dout.valid = 0` (OUT_REG=1); the next group needs 4 full transactions before cfg is acked.

Source files
------------

// File: rtl/tr_cnt_lvl.sv
// rtl/tr_cnt_lvl.sv - transaction grouper: adds one outer eot level every cfg top-level transactions
// Streams are flattened dti ports: <name>_data / <name>_valid / <name>_ready.
module tr_cnt_lvl #(
    parameter int W_DATA  = 8,
    parameter int LVL_IN  = 1,
    parameter int W_CFG   = 16,
    parameter int OUT_REG = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [W_DATA+LVL_IN-1:0] din_data,
    input  logic                     din_valid,
    output logic                     din_ready,
    input  logic [W_CFG-1:0]         cfg_data,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    output logic [W_DATA+LVL_IN:0]   dout_data,
    output logic                     dout_valid,
    input  logic                     dout_ready,
    output logic [W_CFG-1:0]         grp_idx
);

    logic [W_CFG-1:0]         cnt_reg;
    logic [W_CFG-1:0]         cfg_eff;
    logic [W_CFG-1:0]         cfg_last;
    logic                     last;
    logic                     eot_top;
    logic                     acc;
    logic                     done;
    logic [W_DATA+LVL_IN:0]   mapped;

    // A zero group size behaves as one so the counter can never wrap.
    assign cfg_eff  = (cfg_data == '0) ? W_CFG'(1) : cfg_data;
    assign cfg_last = cfg_eff - W_CFG'(1);
    assign last     = (cnt_reg == cfg_last);
    assign eot_top  = din_data[W_DATA+LVL_IN-1];
    assign acc      = din_valid && din_ready;
    assign done     = acc && eot_top && last;

    assign mapped    = {last, din_data};
    assign cfg_ready = done;
    assign grp_idx   = cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (done) begin
            cnt_reg <= '0;
        end else if (acc && eot_top) begin
            cnt_reg <= cnt_reg + W_CFG'(1);
        end
    end

    generate
        if (OUT_REG != 0) begin : g_reg
            logic                   ovalid;
            logic [W_DATA+LVL_IN:0] odata;

            // Full-throughput skid-free stage: load allowed while draining.
            assign din_ready  = cfg_valid && (!ovalid || dout_ready);
            assign dout_valid = ovalid;
            assign dout_data  = odata;

            always_ff @(posedge clk) begin
                if (rst) begin
                    ovalid <= 1'b0;
                    odata  <= '0;
                end else if (acc) begin
                    ovalid <= 1'b1;
                    odata  <= mapped;
                end else if (dout_ready) begin
                    ovalid <= 1'b0;
                end
            end
        end else begin : g_comb
            assign din_ready  = dout_ready && cfg_valid;
            assign dout_valid = din_valid && cfg_valid;
            assign dout_data  = mapped;
        end
    endgenerate

endmodule
